// File: rtl/alu_md_pkg.sv
// Shared definitions for the EX-stage ALU: op codes, FSM states and op-class helpers.
package alu_md_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [3:0] {
        OP_PASS     = 4'd0,
        OP_AND      = 4'd1,
        OP_OR       = 4'd2,
        OP_XOR      = 4'd3,
        OP_ADDS     = 4'd4,
        OP_ADDU     = 4'd5,
        OP_SUBS     = 4'd6,
        OP_SUBU     = 4'd7,
        OP_SHRL     = 4'd8,
        OP_SHLL     = 4'd9,
        OP_SHRA     = 4'd10,
        OP_MUL      = 4'd11,
        OP_MULHU    = 4'd12,
        OP_DIVU     = 4'd13,
        OP_REMU     = 4'd14,
        OP_PASS_ALT = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;

    function automatic logic is_iter_op(input op_t op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // MULHU takes the upper product half; REMU takes the remainder, which sits in the upper half too.
    function automatic logic selects_high(input op_t op);
        return (op == OP_MULHU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// Operand/result handshake bundle between the EX stage and the ALU.
interface alu_md_if #(
    parameter int DATA_W = alu_md_pkg::DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_0;
    logic [DATA_W-1:0] in_1;
    logic [3:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic              of;
    logic              dz;

    modport master (
        output in_valid, in_0, in_1, op, out_ready,
        input  in_ready, out_valid, out, of, dz
    );

    modport slave (
        input  in_valid, in_0, in_1, op, out_ready,
        output in_ready, out_valid, out, of, dz
    );
endinterface

// File: rtl/alu_md_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// A single 2*DATA_W accumulator holds {hi, lo} for multiply and {remainder, quotient} for divide.
module alu_md_muldiv_iter
    import alu_md_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   res
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] LAST = SH_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] acc_reg;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W-1:0]   opnd_reg;
    logic                div_reg;
    logic                busy_reg;
    logic [SH_W-1:0]     cnt_reg;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*DATA_W-1:DATA_W]} + {1'b0, opnd_reg};
        div_diff = acc_reg[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_reg};
        acc_next = {1'b0, acc_reg[2*DATA_W-1:1]};
        if (div_reg) begin
            // Borrow clear means the shifted partial remainder covers the divisor.
            if (!div_diff[DATA_W])
                acc_next = {div_diff[DATA_W-1:0], acc_reg[DATA_W-2:0], 1'b1};
            else
                acc_next = {acc_reg[2*DATA_W-2:0], 1'b0};
        end else if (acc_reg[0]) begin
            acc_next = {mul_sum, acc_reg[DATA_W-1:1]};
        end
    end

    // The final step's result is handed out combinationally so the caller loads it on the same edge.
    assign done = busy_reg && (cnt_reg == LAST);
    assign res  = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg  <= '0;
            opnd_reg <= '0;
            div_reg  <= 1'b0;
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (start) begin
            acc_reg  <= {{DATA_W{1'b0}}, a};
            opnd_reg <= b;
            div_reg  <= is_div;
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + SH_W'(1);
            if (done)
                busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_md.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV,
// with a registered valid/ready result port.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    alu_md_if.slave  bus
);
    localparam int SH_W = $clog2(DATA_W);

    op_t               op_in;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] alu_res;
    logic              alu_of;
    logic              alu_dz;
    logic              div_zero;

    state_t            state_reg, state_next;
    op_t               op_reg, op_next;
    logic [DATA_W-1:0] out_reg, out_next;
    logic              of_reg, of_next;
    logic              dz_reg, dz_next;
    logic              out_valid_reg, out_valid_next;

    logic                in_ready;
    logic                accept;
    logic                start_iter;
    logic                md_done;
    logic [2*DATA_W-1:0] md_res;

    assign op_in    = op_t'(bus.op);
    assign a        = bus.in_0;
    assign b        = bus.in_1;
    assign shamt    = b[SH_W-1:0];
    assign sum      = a + b;
    assign diff     = a - b;
    assign div_zero = (b == '0);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_logic
            assign logic_res[gi] = (op_in == OP_AND) ? (a[gi] & b[gi]) :
                                   (op_in == OP_OR)  ? (a[gi] | b[gi]) :
                                                       (a[gi] ^ b[gi]);
        end
    endgenerate

    always_comb begin
        alu_res = a;
        alu_of  = 1'b0;
        alu_dz  = 1'b0;
        case (op_in)
            OP_AND, OP_OR, OP_XOR: alu_res = logic_res;
            OP_ADDS: begin
                alu_res = sum;
                alu_of  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUBS: begin
                alu_res = diff;
                alu_of  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_SHRL: alu_res = a >> shamt;
            OP_SHLL: alu_res = a << shamt;
            OP_SHRA: alu_res = DATA_W'($signed(a) >>> shamt);
            // Only reached on the single-cycle path when the divisor is zero.
            OP_DIVU: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            OP_REMU: begin
                alu_res = a;
                alu_dz  = 1'b1;
            end
            default: alu_res = a;
        endcase
    end

    assign in_ready   = (state_reg == ST_IDLE) && (!out_valid_reg || bus.out_ready);
    assign accept     = bus.in_valid && in_ready;
    assign start_iter = accept && is_iter_op(op_in) && !(is_div_op(op_in) && div_zero);

    alu_md_muldiv_iter #(
        .DATA_W (DATA_W)
    ) muldiv_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start_iter),
        .is_div (is_div_op(op_in)),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .res    (md_res)
    );

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        out_next       = out_reg;
        of_next        = of_reg;
        dz_next        = dz_reg;
        out_valid_next = out_valid_reg && !bus.out_ready;
        case (state_reg)
            ST_IDLE: begin
                if (start_iter) begin
                    op_next    = op_in;
                    state_next = is_div_op(op_in) ? ST_DIV : ST_MUL;
                end else if (accept) begin
                    out_next       = alu_res;
                    of_next        = alu_of;
                    dz_next        = alu_dz;
                    out_valid_next = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                // The output register was drained at accept, so the result can always land here.
                if (md_done) begin
                    out_next       = selects_high(op_reg) ? md_res[2*DATA_W-1:DATA_W]
                                                          : md_res[DATA_W-1:0];
                    of_next        = 1'b0;
                    dz_next        = 1'b0;
                    out_valid_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_PASS;
            out_reg       <= '0;
            of_reg        <= 1'b0;
            dz_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            out_reg       <= out_next;
            of_reg        <= of_next;
            dz_reg        <= dz_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out       = out_reg;
    assign bus.of        = of_reg;
    assign bus.dz        = dz_reg;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md at DATA_W = 32 and DATA_W = 8, directed cases plus
// randomized ops against an arithmetic reference model.
module tb_alu_md;
    import alu_md_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_md_if #(.DATA_W(32)) bus32 ();
    alu_md_if #(.DATA_W(8))  bus8 ();

    alu_md #(.DATA_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_md #(.DATA_W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic ordy);
        if (w == 32) begin
            bus32.in_valid = v; bus32.op = op; bus32.in_0 = a; bus32.in_1 = b; bus32.out_ready = ordy;
        end else begin
            bus8.in_valid = v; bus8.op = op; bus8.in_0 = a[7:0]; bus8.in_1 = b[7:0]; bus8.out_ready = ordy;
        end
    endtask

    task automatic observe(input int w, output logic rdy, output logic ov, output logic [31:0] o,
                           output logic ofv, output logic dzv);
        if (w == 32) begin
            rdy = bus32.in_ready; ov = bus32.out_valid; o = bus32.out; ofv = bus32.of; dzv = bus32.dz;
        end else begin
            rdy = bus8.in_ready; ov = bus8.out_valid; o = {24'b0, bus8.out}; ofv = bus8.of; dzv = bus8.dz;
        end
    endtask

    // Reference: operands as integers in 64-bit arithmetic, reduced modulo 2^w.
    function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a_in,
                                  input logic [31:0] b_in, output logic [31:0] r,
                                  output logic ofv, output logic dzv);
        logic [63:0] mask, a, b, r64;
        longint as, bs, mx, mn, s;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a    = {32'b0, a_in} & mask;
        b    = {32'b0, b_in} & mask;
        sh   = int'(b % 64'(w));
        as   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        bs   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        mx   = (longint'(1) << (w - 1)) - 1;
        mn   = -(longint'(1) << (w - 1));
        ofv  = 1'b0;
        dzv  = 1'b0;
        r64  = a;
        case (op)
            4'd1:  r64 = a & b;
            4'd2:  r64 = a | b;
            4'd3:  r64 = a ^ b;
            4'd4: begin r64 = (a + b) & mask; s = as + bs; ofv = (s > mx) || (s < mn); end
            4'd5:  r64 = (a + b) & mask;
            4'd6: begin r64 = (a - b) & mask; s = as - bs; ofv = (s > mx) || (s < mn); end
            4'd7:  r64 = (a - b) & mask;
            4'd8:  r64 = a >> sh;
            4'd9:  r64 = (a << sh) & mask;
            4'd10: r64 = 64'(as >>> sh) & mask;
            4'd11: r64 = (a * b) & mask;
            4'd12: r64 = ((a * b) >> w) & mask;
            4'd13: begin r64 = (b == 0) ? mask : a / b; dzv = (b == 0); end
            4'd14: begin r64 = (b == 0) ? a : a % b;    dzv = (b == 0); end
            default: r64 = a;
        endcase
        r = r64[31:0];
    endfunction

    // One transaction: wait for ready, present, scramble inputs after accept, measure latency.
    task automatic do_op(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_o, input logic exp_of, input logic exp_dz,
                         input string tag);
        logic rdy, ov, ofv, dzv;
        logic [31:0] o, bm;
        int lat, guard;
        logic multi, busy_rdy;
        bm    = (w == 32) ? b : {24'b0, b[7:0]};
        multi = (op == 4'd11) || (op == 4'd12) || (((op == 4'd13) || (op == 4'd14)) && (bm != 0));
        @(negedge clk);
        observe(w, rdy, ov, o, ofv, dzv);
        guard = 0;
        while (!rdy && guard < 100) begin
            @(negedge clk);
            observe(w, rdy, ov, o, ofv, dzv);
            guard++;
        end
        drive(w, 1'b1, op, a, b, 1'b1);
        lat      = 0;
        busy_rdy = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1)
                drive(w, 1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b1);
            observe(w, rdy, ov, o, ofv, dzv);
            if (!ov && rdy) busy_rdy = 1'b1;
        end while (!ov && lat < 100);
        chk({tag, ".lat"}, 32'(lat), multi ? 32'(w + 1) : 32'd1);
        chk({tag, ".out"}, o, exp_o);
        chk({tag, ".of"}, {31'b0, ofv}, {31'b0, exp_of});
        chk({tag, ".dz"}, {31'b0, dzv}, {31'b0, exp_dz});
        if (multi) chk({tag, ".busy_rdy"}, {31'b0, busy_rdy}, 32'd0);
        $display("txn %s w=%0d op=%0d a=%h b=%h out=%h of=%b dz=%b lat=%0d",
                 tag, w, op, a, b, o, ofv, dzv, lat);
    endtask

    task automatic reset_state_check(input int w);
        logic rdy, ov, ofv, dzv;
        logic [31:0] o;
        observe(w, rdy, ov, o, ofv, dzv);
        chk("rst.out", o, 32'd0);
        chk("rst.of", {31'b0, ofv}, 32'd0);
        chk("rst.dz", {31'b0, dzv}, 32'd0);
        chk("rst.valid", {31'b0, ov}, 32'd0);
        chk("rst.rdy", {31'b0, rdy}, 32'd1);
    endtask

    task automatic backpressure(input int w);
        logic rdy, ov, ofv, dzv, d0, d1;
        logic [31:0] o, a, b, e, a2, b2, e2;
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
        model(w, 4'd5, a, b, e, d0, d1);
        model(w, 4'd5, a2, b2, e2, d0, d1);
        @(negedge clk);
        drive(w, 1'b1, 4'd5, a, b, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 4'd5, $urandom, $urandom, 1'b0);
        observe(w, rdy, ov, o, ofv, dzv);
        chk("bp.valid", {31'b0, ov}, 32'd1);
        chk("bp.out", o, e);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            observe(w, rdy, ov, o, ofv, dzv);
            chk("bp.rdy", {31'b0, rdy}, 32'd0);
            chk("bp.hold", o, e);
        end
        drive(w, 1'b1, 4'd5, a2, b2, 1'b1);
        #1;
        observe(w, rdy, ov, o, ofv, dzv);
        chk("bp.rdy_release", {31'b0, rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        observe(w, rdy, ov, o, ofv, dzv);
        chk("bp.reload_valid", {31'b0, ov}, 32'd1);
        chk("bp.reload_out", o, e2);
        $display("txn bp w=%0d held=%h next=%h", w, e, o);
    endtask

    task automatic stream(input int w);
        logic rdy, ov, ofv, dzv, d0, d1;
        logic [31:0] o;
        logic [3:0]  ops [4];
        logic [31:0] av [4], bv [4], ev [4];
        for (int i = 0; i < 4; i++) begin
            ops[i] = (i % 2 == 0) ? 4'd5 : 4'd3;
            av[i]  = $urandom;
            bv[i]  = $urandom;
            model(w, ops[i], av[i], bv[i], ev[i], d0, d1);
        end
        @(negedge clk);
        drive(w, 1'b1, ops[0], av[0], bv[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 3) drive(w, 1'b1, ops[i+1], av[i+1], bv[i+1], 1'b1);
            else       drive(w, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
            observe(w, rdy, ov, o, ofv, dzv);
            chk("stream.valid", {31'b0, ov}, 32'd1);
            chk("stream.out", o, ev[i]);
            $display("txn stream w=%0d i=%0d out=%h", w, i, o);
        end
    endtask

    task automatic reset_mid_div(input int w);
        logic rdy, ov, ofv, dzv, seen;
        logic [31:0] o;
        @(negedge clk);
        drive(w, 1'b1, 4'd13, 32'd100, 32'd7, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        observe(w, rdy, ov, o, ofv, dzv);
        chk("rstmid.valid", {31'b0, ov}, 32'd0);
        chk("rstmid.out", o, 32'd0);
        chk("rstmid.rdy", {31'b0, rdy}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < w + 4; k++) begin
            @(negedge clk);
            observe(w, rdy, ov, o, ofv, dzv);
            if (ov) seen = 1'b1;
        end
        chk("rstmid.no_partial", {31'b0, seen}, 32'd0);
        $display("txn rstmid w=%0d", w);
        do_op(w, 4'd5, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, "rstmid.addu");
    endtask

    task automatic random_ops(input int w, input int n);
        logic [3:0]  op;
        logic [31:0] a, b, e;
        logic        eo, ed;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            model(w, op, a, b, e, eo, ed);
            do_op(w, op, a, b, e, eo, ed, "rand");
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(32, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        drive(8,  1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        reset_state_check(32);
        reset_state_check(8);

        do_op(32, 4'd4,  32'h7FFFFFFF, 32'h1,  32'h80000000, 1'b1, 1'b0, "adds");
        do_op(32, 4'd4,  32'h0,        32'h0,  32'h0,        1'b0, 1'b0, "adds0");
        do_op(32, 4'd6,  32'h80000000, 32'h1,  32'h7FFFFFFF, 1'b1, 1'b0, "subs");
        do_op(32, 4'd10, 32'h80000000, 32'h4,  32'hF8000000, 1'b0, 1'b0, "shra");
        do_op(32, 4'd8,  32'h80000000, 32'h4,  32'h08000000, 1'b0, 1'b0, "shrl");
        do_op(32, 4'd8,  32'h80000000, 32'h25, 32'h04000000, 1'b0, 1'b0, "shrl_amt");
        do_op(32, 4'd11, 32'hFFFFFFFF, 32'h2,  32'hFFFFFFFE, 1'b0, 1'b0, "mul");
        do_op(32, 4'd12, 32'hFFFFFFFF, 32'h2,  32'h00000001, 1'b0, 1'b0, "mulhu");
        do_op(32, 4'd13, 32'd100,      32'd7,  32'd14,       1'b0, 1'b0, "divu");
        do_op(32, 4'd14, 32'd100,      32'd7,  32'd2,        1'b0, 1'b0, "remu");
        do_op(32, 4'd13, 32'd5,        32'd0,  32'hFFFFFFFF, 1'b0, 1'b1, "divz");
        do_op(32, 4'd14, 32'd5,        32'd0,  32'd5,        1'b0, 1'b1, "remz");

        do_op(8, 4'd4,  32'h7F, 32'h1,  32'h80, 1'b1, 1'b0, "adds8");
        do_op(8, 4'd6,  32'h80, 32'h1,  32'h7F, 1'b1, 1'b0, "subs8");
        do_op(8, 4'd10, 32'h80, 32'h4,  32'hF8, 1'b0, 1'b0, "shra8");
        do_op(8, 4'd8,  32'h80, 32'h4,  32'h08, 1'b0, 1'b0, "shrl8");
        do_op(8, 4'd8,  32'h80, 32'h25, 32'h04, 1'b0, 1'b0, "shrl_amt8");
        do_op(8, 4'd11, 32'hFF, 32'h2,  32'hFE, 1'b0, 1'b0, "mul8");
        do_op(8, 4'd12, 32'hFF, 32'h2,  32'h01, 1'b0, 1'b0, "mulhu8");
        do_op(8, 4'd13, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, "divu8");
        do_op(8, 4'd14, 32'd100, 32'd7, 32'd2,  1'b0, 1'b0, "remu8");
        do_op(8, 4'd13, 32'd5,  32'd0,  32'hFF, 1'b0, 1'b1, "divz8");

        backpressure(32);
        backpressure(8);
        stream(32);
        stream(8);
        reset_mid_div(32);
        reset_mid_div(8);
        random_ops(32, 60);
        random_ops(8, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
